// File: rtl/mux_pipe_reg_pkg.sv
// Shared definitions for the operand selector pipeline register.
// Holds the buffer-occupancy state encoding used by the handshake FSM.
package mux_pipe_reg_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/mux_pipe_reg_if.sv
// Upstream/downstream handshake bundle for mux_pipe_reg.
// master drives the beats and out_ready; slave is the pipeline register.
interface mux_pipe_reg_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4
);
   localparam int unsigned SEL_W = $clog2(NUM_IN);

   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic                    out_sel_err;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_sel_err, out_valid
   );

   modport slave (
      input  in_data, sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_sel_err, out_valid
   );
endinterface

// File: rtl/mux_pipe_reg_mux_nway.sv
// Combinational N-way word selector; out-of-range select yields zero plus sel_err.
// Loop compare keeps unused select codes on the error path instead of producing X.
module mux_nway #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4
) (
   input  logic [NUM_IN*WIDTH-1:0]    in_data,
   input  logic [$clog2(NUM_IN)-1:0]  sel,
   output logic [WIDTH-1:0]           word,
   output logic                       sel_err
);
   localparam int unsigned SEL_W = $clog2(NUM_IN);

   always_comb begin
      word    = '0;
      sel_err = 1'b1;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            word    = in_data[i*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end
endmodule

// File: rtl/mux_pipe_reg.sv
// Selects one of NUM_IN words and buffers it in a two-entry (main + skid) register
// with valid/ready flow control; in_ready comes straight from a flop.
module mux_pipe_reg
   import mux_pipe_reg_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4
) (
   input logic            clk,
   input logic            reset,
   mux_pipe_reg_if.slave  bus
);
   logic [WIDTH-1:0] sel_word;
   logic             sel_err;

   state_e           state;
   state_e           state_next;
   logic             push;
   logic             pop;
   logic             load_main_new;
   logic             load_main_skid;
   logic             load_skid;

   logic [WIDTH-1:0] main_data;
   logic             main_err;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic             in_ready_q;
   logic             out_valid_q;

   mux_nway #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_mux (
      .in_data (bus.in_data),
      .sel     (bus.sel),
      .word    (sel_word),
      .sel_err (sel_err)
   );

   assign push = bus.in_valid & in_ready_q & ~bus.flush;
   assign pop  = out_valid_q & bus.out_ready;

   // State register; handshake outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_next;
         in_ready_q  <= (state_next != ST_TWO);
         out_valid_q <= (state_next != ST_EMPTY);
      end
   end

   // Next-state: flush wins over any push or pop in the same cycle.
   always_comb begin
      state_next = state;
      if (bus.flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (push) state_next = ST_ONE;
            ST_ONE: begin
               if (push && !pop)      state_next = ST_TWO;
               else if (pop && !push) state_next = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
         endcase
      end
   end

   // Datapath load enables.
   always_comb begin
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!bus.flush) begin
         case (state)
            ST_EMPTY: load_main_new = push;
            ST_ONE: begin
               load_main_new = push & pop;
               load_skid     = push & ~pop;
            end
            ST_TWO:   load_main_skid = pop;
            default: ;
         endcase
      end
   end

   // Main and skid word registers; main keeps its value across flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data <= '0;
         main_err  <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         if (load_main_new) begin
            main_data <= sel_word;
            main_err  <= sel_err;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_err  <= skid_err;
         end
         if (load_skid) begin
            skid_data <= sel_word;
            skid_err  <= sel_err;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = main_data;
   assign bus.out_sel_err = main_err;
endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: vector table on a 4-input instance plus
// hand-written reset and out-of-range select sequences on a 3-input instance.
module tb_mux_pipe_reg;

   typedef struct {
      logic [127:0] data;
      logic [1:0]   sel;
      logic         iv;
      logic         flush;
      logic         ordy;
      logic         exp_valid;
      logic [31:0]  exp_data;
      logic         exp_err;
      logic         exp_ready;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vecs[$];

   mux_pipe_reg_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
   mux_pipe_reg_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

   mux_pipe_reg #(.WIDTH(32), .NUM_IN(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   mux_pipe_reg #(.WIDTH(32), .NUM_IN(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] w4(logic [31:0] a, logic [31:0] b,
                                       logic [31:0] c, logic [31:0] d);
      return {d, c, b, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [127:0] d, input logic [1:0] s, input logic iv,
                      input logic fl, input logic ordy, input logic ev,
                      input logic [31:0] ed, input logic ee, input logic er);
      vec_t v;
      v.data = d; v.sel = s; v.iv = iv; v.flush = fl; v.ordy = ordy;
      v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee; v.exp_ready = er;
      vecs.push_back(v);
   endtask

   initial begin
      logic [127:0] d;
      checks   = 0;
      failures = 0;
      d = w4(32'h11, 32'h22, 32'h33, 32'h44);

      // Select sweep, one push per cycle with downstream always ready
      add(d, 2'd0, 1, 0, 1, 1, 32'h11, 0, 1);
      add(d, 2'd1, 1, 0, 1, 1, 32'h22, 0, 1);
      add(d, 2'd2, 1, 0, 1, 1, 32'h33, 0, 1);
      add(d, 2'd3, 1, 0, 1, 1, 32'h44, 0, 1);
      add(d, 2'd0, 0, 0, 1, 0, 32'h44, 0, 1);
      // Backpressure: fill main + skid, offered beat refused, then drain in order
      add(w4(32'hA, 0, 0, 0), 2'd0, 1, 0, 0, 1, 32'hA, 0, 1);
      add(w4(32'hB, 0, 0, 0), 2'd0, 1, 0, 0, 1, 32'hA, 0, 0);
      add(w4(32'hD, 0, 0, 0), 2'd0, 1, 0, 0, 1, 32'hA, 0, 0);
      add(d, 2'd0, 0, 0, 1, 1, 32'hB, 0, 1);
      add(d, 2'd0, 0, 0, 1, 0, 32'hB, 0, 1);
      // Flush while TWO with a new beat offered
      add(d, 2'd0, 1, 0, 0, 1, 32'h11, 0, 1);
      add(d, 2'd1, 1, 0, 0, 1, 32'h11, 0, 0);
      add(w4(32'hC, 32'hC, 32'hC, 32'hC), 2'd0, 1, 1, 0, 0, 32'h11, 0, 1);
      add(d, 2'd0, 0, 0, 1, 0, 32'h11, 0, 1);
      // Flush in ONE overrides an accepted push and a pop
      add(d, 2'd2, 1, 0, 1, 1, 32'h33, 0, 1);
      add(w4(32'hC, 32'hC, 32'hC, 32'hC), 2'd0, 1, 1, 1, 0, 32'h33, 0, 1);
      add(d, 2'd0, 0, 0, 1, 0, 32'h33, 0, 1);
      // Streaming push & pop, sel alternating 0/1
      for (int i = 0; i < 8; i++)
         add(d, 2'(i % 2), 1, 0, 1, 1, (i % 2 == 0) ? 32'h11 : 32'h22, 0, 1);
      add(d, 2'd0, 0, 0, 1, 0, 32'h22, 0, 1);

      bus4.in_data = d;  bus4.sel = 2'd0; bus4.in_valid = 1'b1;
      bus4.flush = 1'b0; bus4.out_ready = 1'b1;
      bus3.in_data = 96'({32'h33, 32'h22, 32'h11});
      bus3.sel = 2'd0; bus3.in_valid = 1'b1;
      bus3.flush = 1'b0; bus3.out_ready = 1'b1;

      // Reset held two cycles with in_valid asserted
      reset = 1'b1;
      step();
      step();
      chk("rst_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_data",  bus4.out_data, 32'd0);
      chk("rst_ready", 32'(bus4.in_ready), 32'd1);
      chk("rst_err",   32'(bus4.out_sel_err), 32'd0);
      bus4.in_valid = 1'b0;
      bus3.in_valid = 1'b0;
      reset = 1'b0;
      step();
      chk("post_rst_valid", 32'(bus4.out_valid), 32'd0);
      chk("post_rst_ready", 32'(bus4.in_ready), 32'd1);

      foreach (vecs[i]) begin
         bus4.in_data   = vecs[i].data;
         bus4.sel       = vecs[i].sel;
         bus4.in_valid  = vecs[i].iv;
         bus4.flush     = vecs[i].flush;
         bus4.out_ready = vecs[i].ordy;
         step();
         chk($sformatf("v%0d_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("v%0d_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_ready));
         chk($sformatf("v%0d_err", i), 32'(bus4.out_sel_err), 32'(vecs[i].exp_err));
         if (vecs[i].exp_valid || i > 0)
            chk($sformatf("v%0d_data", i), bus4.out_data, vecs[i].exp_data);
      end
      bus4.in_valid = 1'b0;

      // Out-of-range select on the 3-input instance flags only that beat
      bus3.sel = 2'd3; bus3.in_valid = 1'b1;
      step();
      chk("oor_valid", 32'(bus3.out_valid), 32'd1);
      chk("oor_data",  bus3.out_data, 32'd0);
      chk("oor_err",   32'(bus3.out_sel_err), 32'd1);
      bus3.sel = 2'd2;
      step();
      chk("top_data", bus3.out_data, 32'h33);
      chk("top_err",  32'(bus3.out_sel_err), 32'd0);
      bus3.sel = 2'd1;
      step();
      chk("mid_data", bus3.out_data, 32'h22);
      chk("mid_err",  32'(bus3.out_sel_err), 32'd0);
      bus3.in_valid = 1'b0;
      step();
      chk("idle3_valid", 32'(bus3.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
